// File: rtl/mem_wb_skid_if.sv
// Handshake and entry bus between the MEM stage, the MEM/WB skid register and the WB stage.
// The slave modport is the skid buffer's view; the master modport is the driver side.
interface mem_wb_skid_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              valid_i;
  logic              ready_o;
  logic              flush_i;
  logic [1:0]        WB_i;
  logic [ADDR_W-1:0] RDaddr_i;
  logic [DATA_W-1:0] ALUdata_i;
  logic [DATA_W-1:0] DataMem_i;
  logic              valid_o;
  logic              ready_i;
  logic              RegWrite_o;
  logic              MemToReg_o;
  logic [ADDR_W-1:0] RDaddr_o;
  logic [DATA_W-1:0] ALUdata_o;
  logic [DATA_W-1:0] DataMem_o;
  logic [DATA_W-1:0] WBdata_o;
  logic [31:0]       retire_cnt_o;

  modport master (
    output valid_i, flush_i, WB_i, RDaddr_i, ALUdata_i, DataMem_i, ready_i,
    input  ready_o, valid_o, RegWrite_o, MemToReg_o, RDaddr_o, ALUdata_o,
           DataMem_o, WBdata_o, retire_cnt_o
  );

  modport slave (
    input  valid_i, flush_i, WB_i, RDaddr_i, ALUdata_i, DataMem_i, ready_i,
    output ready_o, valid_o, RegWrite_o, MemToReg_o, RDaddr_o, ALUdata_o,
           DataMem_o, WBdata_o, retire_cnt_o
  );
endinterface

// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with a one-entry skid buffer, so ready_o comes straight from a flop.
// Also counts retired register writes.
module mem_wb_skid #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 5,
  parameter int          ZERO_GATE   = 1,
  parameter logic [31:0] RETIRE_INIT = 32'd0
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_wb_skid_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [1:0]        wb;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
  } entry_t;

  state_t      r_state, w_nextState;
  entry_t      r_main, r_skid, w_nextMain, w_nextSkid, w_inEntry;
  logic [31:0] r_retireCnt;
  logic        w_mainValid, w_skidValid, w_accept, w_pop;
  logic        w_regWrite, w_memToReg, w_retire;

  // Valid bits are encoded by the state: main valid unless EMPTY, skid valid only when FULL.
  assign w_mainValid = (r_state != EMPTY);
  assign w_skidValid = (r_state == FULL);

  assign w_inEntry = '{wb: bus.WB_i, rd: bus.RDaddr_i, alu: bus.ALUdata_i, mem: bus.DataMem_i};

  assign w_accept = bus.valid_i & ~w_skidValid & ~bus.flush_i;
  assign w_pop    = w_mainValid & bus.ready_i;

  assign w_regWrite = r_main.wb[0] & w_mainValid & ~((ZERO_GATE != 0) && (r_main.rd == '0));
  assign w_memToReg = r_main.wb[1] & w_mainValid;
  assign w_retire   = w_pop & w_regWrite & ~bus.flush_i;

  always_comb begin
    w_nextState = r_state;
    w_nextMain  = r_main;
    w_nextSkid  = r_skid;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_nextState = ONE;
          w_nextMain  = w_inEntry;
        end
      end
      ONE: begin
        if (w_accept && !w_pop) begin
          w_nextState = FULL;
          w_nextSkid  = w_inEntry;
        end else if (w_pop && !w_accept) begin
          w_nextState = EMPTY;
        end else if (w_pop && w_accept) begin
          w_nextMain = w_inEntry;
        end
      end
      FULL: begin
        if (w_pop) begin
          w_nextState = ONE;
          w_nextMain  = r_skid;
        end
      end
      default: w_nextState = EMPTY;
    endcase
    // Flush wins over everything; data fields of the dropped entries are left as don't-care.
    if (bus.flush_i) begin
      w_nextState = EMPTY;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_retireCnt <= RETIRE_INIT;
    end else begin
      r_state <= w_nextState;
      r_main  <= w_nextMain;
      r_skid  <= w_nextSkid;
      if (w_retire) begin
        r_retireCnt <= r_retireCnt + 32'd1;
      end
    end
  end

  assign bus.ready_o      = ~w_skidValid;
  assign bus.valid_o      = w_mainValid;
  assign bus.RegWrite_o   = w_regWrite;
  assign bus.MemToReg_o   = w_memToReg;
  assign bus.RDaddr_o     = r_main.rd;
  assign bus.ALUdata_o    = r_main.alu;
  assign bus.DataMem_o    = r_main.mem;
  assign bus.WBdata_o     = w_memToReg ? r_main.mem : r_main.alu;
  assign bus.retire_cnt_o = r_retireCnt;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed self-checking bench for mem_wb_skid; a second instance starts its counter near wrap.
module tb_mem_wb_skid;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  mem_wb_skid_if #(.DATA_W(32), .ADDR_W(5)) busA ();
  mem_wb_skid_if #(.DATA_W(32), .ADDR_W(5)) busB ();

  mem_wb_skid #(.DATA_W(32), .ADDR_W(5), .ZERO_GATE(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (busA)
  );

  mem_wb_skid #(.DATA_W(32), .ADDR_W(5), .ZERO_GATE(1), .RETIRE_INIT(32'hFFFF_FFFE)) dutWrap (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] wb, input logic [4:0] rd,
                               input logic [31:0] alu, input logic [31:0] mem,
                               input logic rdy, input logic fl);
    busA.valid_i   = v;
    busA.WB_i      = wb;
    busA.RDaddr_i  = rd;
    busA.ALUdata_i = alu;
    busA.DataMem_i = mem;
    busA.ready_i   = rdy;
    busA.flush_i   = fl;
  endtask

  task automatic applyStimulusB(input logic v, input logic [4:0] rd, input logic [31:0] alu, input logic rdy);
    busB.valid_i   = v;
    busB.WB_i      = 2'b01;
    busB.RDaddr_i  = rd;
    busB.ALUdata_i = alu;
    busB.DataMem_i = 32'd0;
    busB.ready_i   = rdy;
    busB.flush_i   = 1'b0;
  endtask

  // Advance one clock and land 1 time unit after the rising edge to sample.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulusB(1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    tick();
    checkOutput("rst_ready", {31'd0, busA.ready_o}, 32'd1);
    checkOutput("rst_valid", {31'd0, busA.valid_o}, 32'd0);
    checkOutput("rst_regwrite", {31'd0, busA.RegWrite_o}, 32'd0);
    checkOutput("rst_wbdata", busA.WBdata_o, 32'd0);
    checkOutput("rst_cnt", busA.retire_cnt_o, 32'd0);
    rst = 1'b0;

    // Single entry flows through with one cycle latency and retires.
    applyStimulus(1'b1, 2'b01, 5'd3, 32'h1234, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("single_valid", {31'd0, busA.valid_o}, 32'd1);
    checkOutput("single_regwrite", {31'd0, busA.RegWrite_o}, 32'd1);
    checkOutput("single_wbdata", busA.WBdata_o, 32'h1234);
    checkOutput("single_rd", {27'd0, busA.RDaddr_o}, 32'd3);
    applyStimulus(1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    checkOutput("single_cnt", busA.retire_cnt_o, 32'd1);
    checkOutput("single_empty", {31'd0, busA.valid_o}, 32'd0);

    // Back-pressure: A and B are held, C is refused, then A and B drain in order.
    applyStimulus(1'b1, 2'b01, 5'd5, 32'hA, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("bp_a_out", busA.ALUdata_o, 32'hA);
    checkOutput("bp_ready_one", {31'd0, busA.ready_o}, 32'd1);
    applyStimulus(1'b1, 2'b01, 5'd6, 32'hB, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("bp_ready_full", {31'd0, busA.ready_o}, 32'd0);
    checkOutput("bp_a_hold", busA.ALUdata_o, 32'hA);
    applyStimulus(1'b1, 2'b01, 5'd7, 32'hC, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("bp_a_stable", busA.ALUdata_o, 32'hA);
    checkOutput("bp_rd_stable", {27'd0, busA.RDaddr_o}, 32'd5);
    applyStimulus(1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    checkOutput("bp_b_out", busA.ALUdata_o, 32'hB);
    checkOutput("bp_ready_back", {31'd0, busA.ready_o}, 32'd1);
    tick();
    checkOutput("bp_c_dropped", {31'd0, busA.valid_o}, 32'd0);
    checkOutput("bp_cnt", busA.retire_cnt_o, 32'd3);

    // MemToReg selects memory data; writes to register 0 are gated and not counted.
    applyStimulus(1'b1, 2'b11, 5'd7, 32'h5, 32'hAA, 1'b0, 1'b0);
    tick();
    checkOutput("mem_wbdata", busA.WBdata_o, 32'hAA);
    checkOutput("mem_memtoreg", {31'd0, busA.MemToReg_o}, 32'd1);
    applyStimulus(1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    checkOutput("mem_cnt", busA.retire_cnt_o, 32'd4);
    applyStimulus(1'b1, 2'b01, 5'd0, 32'h77, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("r0_valid", {31'd0, busA.valid_o}, 32'd1);
    checkOutput("r0_regwrite", {31'd0, busA.RegWrite_o}, 32'd0);
    checkOutput("r0_wbdata", busA.WBdata_o, 32'h77);
    applyStimulus(1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    checkOutput("r0_cnt", busA.retire_cnt_o, 32'd4);

    // Flush from FULL with valid_i and ready_i high: nothing accepted, nothing counted.
    applyStimulus(1'b1, 2'b01, 5'd9, 32'h91, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'b01, 5'd10, 32'h92, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("flush_full", {31'd0, busA.ready_o}, 32'd0);
    applyStimulus(1'b1, 2'b01, 5'd11, 32'h93, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("flush_valid", {31'd0, busA.valid_o}, 32'd0);
    checkOutput("flush_ready", {31'd0, busA.ready_o}, 32'd1);
    checkOutput("flush_cnt", busA.retire_cnt_o, 32'd4);
    applyStimulus(1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    checkOutput("flush_noaccept", {31'd0, busA.valid_o}, 32'd0);

    // Asynchronous reset mid-cycle while FULL.
    applyStimulus(1'b1, 2'b11, 5'd12, 32'hC1, 32'hD1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'b11, 5'd13, 32'hC2, 32'hD2, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("arst_pre_wbdata", busA.WBdata_o, 32'hD1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_ready", {31'd0, busA.ready_o}, 32'd1);
    checkOutput("arst_valid", {31'd0, busA.valid_o}, 32'd0);
    checkOutput("arst_regwrite", {31'd0, busA.RegWrite_o}, 32'd0);
    checkOutput("arst_memtoreg", {31'd0, busA.MemToReg_o}, 32'd0);
    checkOutput("arst_wbdata", busA.WBdata_o, 32'd0);
    checkOutput("arst_cnt", busA.retire_cnt_o, 32'd0);
    rst = 1'b0;

    // Counter wrap on the instance whose counter resets to 0xFFFFFFFE.
    checkOutput("wrap_init", busB.retire_cnt_o, 32'hFFFF_FFFE);
    applyStimulusB(1'b1, 5'd2, 32'h1, 1'b1);
    tick();
    applyStimulusB(1'b1, 5'd2, 32'h2, 1'b1);
    tick();
    checkOutput("wrap_ff", busB.retire_cnt_o, 32'hFFFF_FFFF);
    applyStimulusB(1'b1, 5'd2, 32'h3, 1'b1);
    tick();
    checkOutput("wrap_zero", busB.retire_cnt_o, 32'h0000_0000);
    applyStimulusB(1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    checkOutput("wrap_one", busB.retire_cnt_o, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid.md
MEM_WB_SKID -- requirements
Module: mem_wb_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of ALU and memory data words.
REQ-002 SHALL have parameter ADDR_W, default 5, width of destination register address.
REQ-003 SHALL have parameter ZERO_GATE, default 1, when 1 suppresses writes to register address 0.
REQ-004 SHALL have port clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port valid_i  in  1  upstream (MEM) entry valid.
REQ-007 SHALL have port ready_o  out  1  block can accept an entry this cycle.
REQ-008 SHALL have port flush_i  in  1  discard all held entries.
REQ-009 SHALL have port WB_i  in  2  control: bit0 RegWrite, bit1 MemToReg.
REQ-010 SHALL have port RDaddr_i  in  ADDR_W  destination register.
REQ-011 SHALL have ports ALUdata_i, DataMem_i  in  DATA_W  ALU result, memory read data.
REQ-012 SHALL have port valid_o  out  1  output entry valid.
REQ-013 SHALL have port ready_i  in  1  downstream (WB) accepts output entry.
REQ-014 SHALL have ports RegWrite_o, MemToReg_o  out  1  control of output entry.
REQ-015 SHALL have ports RDaddr_o  out  ADDR_W; ALUdata_o, DataMem_o  out  DATA_W  output entry fields.
REQ-016 SHALL have port WBdata_o  out  DATA_W  selected write-back data: DataMem_o if MemToReg_o else ALUdata_o.
REQ-017 SHALL have port retire_cnt_o  out  32  count of retired register writes.

Function
REQ-018 SHALL hold two entries: main (drives outputs) and skid; each entry = WB, RDaddr, ALUdata, DataMem plus valid bit.
REQ-019 SHALL define accept = valid_i & ready_o & !flush_i and pop = valid_o & ready_i.
REQ-020 SHALL drive ready_o = !skid.valid (registered state only, no combinational path from ready_i).
REQ-021 SHALL drive valid_o = main.valid; all output fields from main entry.
REQ-022 SHALL implement states EMPTY (none valid), ONE (main only), FULL (main+skid).
REQ-023 SHALL transition EMPTY: accept -> ONE with input loaded into main; else stay.
REQ-024 SHALL transition ONE: accept & !pop -> FULL, input into skid; pop & !accept -> EMPTY; accept & pop -> ONE, input into main; neither -> ONE, hold.
REQ-025 SHALL transition FULL: pop -> ONE, skid moved into main; else hold (no accept possible).
REQ-026 SHALL give latency of one cycle from accept in EMPTY to valid_o=1 with that entry's fields.
REQ-027 SHALL preserve entry order; no entry dropped or duplicated except by flush.
REQ-028 SHALL hold all output fields stable while valid_o=1 and ready_i=0.
REQ-029 SHALL, on flush_i=1, clear both valid bits at the next edge (-> EMPTY), ignore valid_i that cycle, and not count a pop that cycle.
REQ-030 SHALL drive RegWrite_o = main.WB[0] & valid_o & !(ZERO_GATE & RDaddr_o==0); MemToReg_o = main.WB[1] & valid_o.
REQ-031 SHALL increment retire_cnt_o by 1 on each pop with RegWrite_o=1 and !flush_i; wrap 0xFFFFFFFF -> 0.
REQ-032 SHALL leave data fields of invalid entries don't-care except as fixed by reset.

Reset
REQ-033 SHALL on rst_i=1 immediately clear: both valid bits, all entry fields to 0, retire_cnt_o to 0; state EMPTY; ready_o=1, valid_o=0, RegWrite_o=0, MemToReg_o=0, WBdata_o=0.
REQ-034 SHALL ignore valid_i while rst_i=1; reset asserted mid-transfer discards all held entries.

Verification
REQ-035 SHALL cover: single entry WB=01, RD=3, ALU=0x1234, ready_i=1 -> next cycle valid_o=1, RegWrite_o=1, WBdata_o=0x1234, then retire_cnt_o=1.
REQ-036 SHALL cover: ready_i=0, three back-to-back valid_i entries A,B,C -> A,B held, ready_o=0 after B, C not accepted; release ready_i -> A then B out in order.
REQ-037 SHALL cover: entry WB=11, ALU=0x5, Mem=0xAA -> WBdata_o=0xAA; entry RD=0, WB=01, ZERO_GATE=1 -> RegWrite_o=0, counter unchanged.
REQ-038 SHALL cover: FULL state, flush_i=1 with valid_i=1 -> next cycle valid_o=0, ready_o=1, counter unchanged.
REQ-039 SHALL cover: retire_cnt_o preloaded near 0xFFFFFFFF via 2 retires past wrap -> value 0x00000000 then 0x00000001.
REQ-040 SHALL cover: rst_i asserted asynchronously mid-cycle in FULL -> outputs per REQ-033 before next clock edge.
